// File: rtl/multu_hilo_unit.sv
// Sequential unsigned HI/LO multiplier: one shift-add step per cycle, the product is
// committed to HI/LO in a single update, and HI/LO are read back through dataOut.
`timescale 1ns/1ps

module multu_hilo_unit #(
  parameter int         WIDTH   = 32,
  parameter logic [5:0] F_MULTU = 6'd24,
  parameter logic [5:0] F_MFHI  = 6'd16,
  parameter logic [5:0] F_MFLO  = 6'd18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] dataOut
);

  localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   product;
  logic [CNT_W-1:0]     count;
  logic [WIDTH:0]       sum;

  // Upper half plus multiplicand, keeping the carry so it survives the right shift.
  always_comb begin
    sum = {1'b0, product[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid && funct == F_MULTU) begin
            mcand   <= dataA;
            mplier  <= dataB;
            product <= '0;
            count   <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (mplier[0]) begin
            product <= {sum, product[WIDTH-1:1]};
          end else begin
            product <= {1'b0, product[2*WIDTH-1:1]};
          end
          mplier <= mplier >> 1;
          count  <= count + CNT_W'(1);
          if (count == LAST) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // HI and LO are written together so readers never see a half-updated product.
          hi    <= product[2*WIDTH-1:WIDTH];
          lo    <= product[WIDTH-1:0];
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);

  always_comb begin
    dataOut = '0;
    if (funct == F_MFHI) begin
      dataOut = hi;
    end else if (funct == F_MFLO) begin
      dataOut = lo;
    end
  end

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Directed self-checking bench for multu_hilo_unit: hand-computed products, latency,
// ignored re-issue, mid-run reset and MFHI/MFLO readback.
`timescale 1ns/1ps

module tb_multu_hilo_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid;
  logic [5:0]       funct;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] dataOut;

  int checks = 0;
  int failures = 0;
  int busyCycles;
  int doneCount;

  multu_hilo_unit #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .valid   (valid),
    .funct   (funct),
    .dataA   (dataA),
    .dataB   (dataB),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo),
    .dataOut (dataOut)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [5:0] f,
                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    valid = v;
    funct = f;
    dataA = a;
    dataB = b;
    @(posedge clk);
    #1;
  endtask

  // Issues one MULTU, then watches 40 cycles; optionally re-issues MULTU or pulses reset.
  task automatic runMultu(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int injectAt, input int resetAt);
    applyStimulus(1'b1, 6'd24, a, b);
    busyCycles = 0;
    doneCount  = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == resetAt) begin
        rst = 1'b1;
        #1;
        checkOutput("reset_mid_run_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_mid_run_hi", {32'd0, hi}, 64'd0);
        checkOutput("reset_mid_run_lo", {32'd0, lo}, 64'd0);
        rst = 1'b0;
      end
      if (busy === 1'b1) busyCycles++;
      if (done === 1'b1) doneCount++;
      if (i == injectAt) begin
        valid = 1'b1;
        funct = 6'd24;
        dataA = 32'd2;
        dataB = 32'd2;
      end else begin
        valid = 1'b0;
        funct = 6'd0;
        dataA = '0;
        dataB = '0;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic readBack(input string tag, input logic [5:0] f,
                          input logic [WIDTH-1:0] expected);
    valid = 1'b1;
    funct = f;
    #1;
    checkOutput(tag, {32'd0, dataOut}, {32'd0, expected});
    valid = 1'b0;
    funct = 6'd0;
  endtask

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    funct = 6'd0;
    dataA = '0;
    dataB = '0;
    #3;
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_done", {63'd0, done}, 64'd0);
    checkOutput("reset_hi", {32'd0, hi}, 64'd0);
    checkOutput("reset_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus(1'b1, 6'd16, 32'd3, 32'd5);
    checkOutput("non_multu_stays_idle", {63'd0, busy}, 64'd0);

    $display("[TB] 3 x 5");
    runMultu(32'd3, 32'd5, -1, -1);
    checkOutput("t1_busy_cycles", 64'(busyCycles), 64'd33);
    checkOutput("t1_done_pulses", 64'(doneCount), 64'd1);
    checkOutput("t1_hi", {32'd0, hi}, 64'h0);
    checkOutput("t1_lo", {32'd0, lo}, 64'hF);
    readBack("t1_mflo", 6'd18, 32'h0000000F);

    $display("[TB] 0xFFFFFFFF x 0xFFFFFFFF");
    runMultu(32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1);
    checkOutput("t2_hi", {32'd0, hi}, 64'hFFFFFFFE);
    checkOutput("t2_lo", {32'd0, lo}, 64'h00000001);
    readBack("t2_mfhi", 6'd16, 32'hFFFFFFFE);

    $display("[TB] 0x12345678 x 0");
    runMultu(32'h12345678, 32'd0, -1, -1);
    checkOutput("t3_hi", {32'd0, hi}, 64'h0);
    checkOutput("t3_lo", {32'd0, lo}, 64'h0);
    readBack("t3_mfhi", 6'd16, 32'h0);
    readBack("t3_mflo", 6'd18, 32'h0);

    $display("[TB] 7 x 9 with re-issued MULTU");
    runMultu(32'd7, 32'd9, 5, -1);
    checkOutput("t4_busy_cycles", 64'(busyCycles), 64'd33);
    checkOutput("t4_done_pulses", 64'(doneCount), 64'd1);
    checkOutput("t4_hi", {32'd0, hi}, 64'h0);
    checkOutput("t4_lo", {32'd0, lo}, 64'd63);

    $display("[TB] 0x10000 x 0x10000 with reset");
    runMultu(32'h00010000, 32'h00010000, -1, 10);
    checkOutput("t5_busy_cycles", 64'(busyCycles), 64'd10);
    checkOutput("t5_done_pulses", 64'(doneCount), 64'd0);
    checkOutput("t5_hi", {32'd0, hi}, 64'h0);
    checkOutput("t5_lo", {32'd0, lo}, 64'h0);

    $display("[TB] 0x80000000 x 4");
    runMultu(32'h80000000, 32'd4, -1, -1);
    checkOutput("t6_hi", {32'd0, hi}, 64'd2);
    checkOutput("t6_lo", {32'd0, lo}, 64'd0);
    readBack("t6_mfhi", 6'd16, 32'd2);
    readBack("t6_mflo", 6'd18, 32'd0);
    readBack("t6_other_funct", 6'd32, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
